// File: rtl/alwaysff_pipe_bank.sv
// alwaysff_pipe_bank: bank of independent elastic register pipelines with flush and occupancy
module alwaysff_pipe_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CHANNELS = 2,
  parameter bit RESET_DATA = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_srst,
  input  logic [CHANNELS-1:0]          i_valid,
  output logic [CHANNELS-1:0]          o_ready,
  input  logic [CHANNELS*WIDTH-1:0]    i_data,
  input  logic [CHANNELS-1:0]          i_flush,
  output logic [CHANNELS-1:0]          o_valid,
  input  logic [CHANNELS-1:0]          i_ready,
  output logic [CHANNELS*WIDTH-1:0]    o_data,
  output logic [CHANNELS*OW-1:0]       o_occ
);
  logic [DEPTH-1:0] v_q [CHANNELS];
  logic [DEPTH-1:0] v_d [CHANNELS];
  logic [DEPTH-1:0] mv  [CHANNELS];
  logic [DEPTH-1:0] ld  [CHANNELS];
  logic [WIDTH-1:0] d_q [CHANNELS][DEPTH];
  // stage moves ripple back from the output so bubbles collapse; ld marks a stage receiving a word
  always_comb begin
    o_ready = '0;
    o_valid = '0;
    o_data = '0;
    o_occ = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mv[c] = '0;
      ld[c] = '0;
      mv[c][DEPTH-1] = v_q[c][DEPTH-1] & i_ready[c];
      for (int k = DEPTH - 2; k >= 0; k--) mv[c][k] = v_q[c][k] & (!v_q[c][k+1] | mv[c][k+1]);
      o_ready[c] = (!v_q[c][0] | mv[c][0]) & !i_flush[c];
      ld[c][0] = i_valid[c] & o_ready[c];
      for (int k = 1; k < DEPTH; k++) ld[c][k] = mv[c][k-1] & !i_flush[c];
      v_d[c] = i_flush[c] ? '0 : ld[c] | (v_q[c] & ~mv[c]);
      o_valid[c] = v_q[c][DEPTH-1];
      o_data[c*WIDTH +: WIDTH] = d_q[c][DEPTH-1];
      o_occ[c*OW +: OW] = OW'($countones(v_q[c]));
    end
  end
  // valid bits: reset clears every stage, otherwise follow the next-state
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < CHANNELS; c++) v_q[c] <= i_srst ? '0 : v_d[c];
  end
  // data stages load only when a word moves in; flush leaves them untouched
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_srst) begin
        if (RESET_DATA) for (int k = 0; k < DEPTH; k++) d_q[c][k] <= INIT_VAL;
      end else begin
        if (ld[c][0]) d_q[c][0] <= i_data[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) if (ld[c][k]) d_q[c][k] <= d_q[c][k-1];
      end
    end
  end
endmodule

// File: tb/tb_alwaysff_pipe_bank.sv
// tb_alwaysff_pipe_bank: directed and random checks of three pipe bank configurations against a word-queue model
module tb_alwaysff_pipe_bank;
  localparam int ND = 3;
  typedef struct {
    logic [7:0] d;
    int age;
  } item_t;
  logic clk = 1'b0;
  logic srst;
  logic [3:0] iv [ND];
  logic [3:0] ir [ND];
  logic [3:0] fl [ND];
  logic [31:0] id [ND];
  logic [3:0] ov [ND];
  logic [3:0] orr [ND];
  logic [31:0] od [ND];
  logic [1:0] ov_a, or_a;
  logic [15:0] od_a;
  logic [3:0] oc_a;
  logic [3:0] ov_b, or_b, oc_b;
  logic [31:0] od_b;
  logic [3:0] ov_c, or_c;
  logic [31:0] od_c;
  logic [19:0] oc_c;
  item_t mq [ND][4][17];
  int mn [ND][4];
  bit hs_m [ND][4];
  bit acc_m [ND][4];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign ov[0] = {2'b00, ov_a};
  assign orr[0] = {2'b00, or_a};
  assign od[0] = {16'h0, od_a};
  assign ov[1] = ov_b;
  assign orr[1] = or_b;
  assign od[1] = od_b;
  assign ov[2] = ov_c;
  assign orr[2] = or_c;
  assign od[2] = od_c;
  alwaysff_pipe_bank #(.WIDTH(8), .DEPTH(3), .CHANNELS(2), .RESET_DATA(1'b1), .INIT_VAL(8'hA5)) u_a (
    .i_clk(clk), .i_srst(srst), .i_valid(iv[0][1:0]), .o_ready(or_a), .i_data(id[0][15:0]),
    .i_flush(fl[0][1:0]), .o_valid(ov_a), .i_ready(ir[0][1:0]), .o_data(od_a), .o_occ(oc_a));
  alwaysff_pipe_bank #(.WIDTH(8), .DEPTH(1), .CHANNELS(4), .RESET_DATA(1'b0), .INIT_VAL(8'h00)) u_b (
    .i_clk(clk), .i_srst(srst), .i_valid(iv[1]), .o_ready(or_b), .i_data(id[1]),
    .i_flush(fl[1]), .o_valid(ov_b), .i_ready(ir[1]), .o_data(od_b), .o_occ(oc_b));
  alwaysff_pipe_bank #(.WIDTH(8), .DEPTH(16), .CHANNELS(4), .RESET_DATA(1'b1), .INIT_VAL(8'h3C)) u_c (
    .i_clk(clk), .i_srst(srst), .i_valid(iv[2]), .o_ready(or_c), .i_data(id[2]),
    .i_flush(fl[2]), .o_valid(ov_c), .i_ready(ir[2]), .o_data(od_c), .o_occ(oc_c));
  function automatic int dep_of(int k);
    return k == 0 ? 3 : k == 1 ? 1 : 16;
  endfunction
  function automatic int nch_of(int k);
    return k == 0 ? 2 : 4;
  endfunction
  function automatic int occ_of(int k, int c);
    return k == 0 ? int'(oc_a[c*2 +: 2]) : k == 1 ? int'(oc_b[c]) : int'(oc_c[c*5 +: 5]);
  endfunction
  task automatic chk(string tag, int k, int c, logic [31:0] obs, logic [31:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d ch%0d: got %0h expected %0h", tag, k, c, obs, req);
    end
  endtask
  // A word is at the output once it heads the queue and has aged DEPTH-1 edges since its accept.
  task automatic cyc();
    #1;
    for (int k = 0; k < ND; k++) begin
      for (int c = 0; c < nch_of(k); c++) begin
        bit ev, er;
        ev = mn[k][c] > 0 && mq[k][c][0].age >= dep_of(k) - 1;
        hs_m[k][c] = ev && ir[k][c];
        er = (mn[k][c] < dep_of(k) || hs_m[k][c]) && !fl[k][c];
        acc_m[k][c] = iv[k][c] && er;
        chk("valid", k, c, 32'(ov[k][c]), 32'(ev));
        chk("ready", k, c, 32'(orr[k][c]), 32'(er));
        chk("occ", k, c, occ_of(k, c), mn[k][c]);
        if (ev) chk("data", k, c, 32'(od[k][c*8 +: 8]), 32'(mq[k][c][0].d));
      end
    end
    @(posedge clk);
    for (int k = 0; k < ND; k++) begin
      for (int c = 0; c < nch_of(k); c++) begin
        if (srst || fl[k][c]) mn[k][c] = 0;
        else begin
          if (hs_m[k][c]) begin
            for (int i = 1; i < mn[k][c]; i++) mq[k][c][i-1] = mq[k][c][i];
            mn[k][c]--;
          end
          for (int i = 0; i < mn[k][c]; i++) mq[k][c][i].age++;
          if (acc_m[k][c]) begin
            mq[k][c][mn[k][c]].d = id[k][c*8 +: 8];
            mq[k][c][mn[k][c]].age = 0;
            mn[k][c]++;
          end
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    srst = 1'b1;
    for (int k = 0; k < ND; k++) begin
      iv[k] = '0;
      ir[k] = '0;
      fl[k] = '0;
      id[k] = '0;
      for (int c = 0; c < 4; c++) mn[k][c] = 0;
    end
    @(negedge clk);
    cyc();
    cyc();
    srst = 1'b0;
    for (int c = 0; c < 2; c++) chk("rst_data", 0, c, 32'(od[0][c*8 +: 8]), 32'h0A5);
    ir[0] = 4'b0011;
    iv[0][0] = 1'b1;
    id[0][7:0] = 8'h11;
    cyc();
    id[0][7:0] = 8'h22;
    cyc();
    id[0][7:0] = 8'h33;
    cyc();
    iv[0][0] = 1'b0;
    chk("lat_valid", 0, 0, 32'(ov[0][0]), 32'h1);
    chk("peak_occ", 0, 0, occ_of(0, 0), 3);
    chk("seq0", 0, 0, 32'(od[0][7:0]), 32'h11);
    cyc();
    chk("seq1", 0, 0, 32'(od[0][7:0]), 32'h22);
    cyc();
    chk("seq2", 0, 0, 32'(od[0][7:0]), 32'h33);
    cyc();
    chk("drained", 0, 0, 32'(ov[0][0]), 32'h0);
    ir[0][0] = 1'b0;
    iv[0][0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id[0][7:0] = 8'hA1 + 8'(i);
      cyc();
    end
    #1;
    chk("full_occ", 0, 0, occ_of(0, 0), 3);
    chk("full_ready", 0, 0, 32'(orr[0][0]), 32'h0);
    ir[0][0] = 1'b1;
    id[0][7:0] = 8'hA4;
    #1;
    chk("full_pass_ready", 0, 0, 32'(orr[0][0]), 32'h1);
    cyc();
    chk("full_pass_occ", 0, 0, occ_of(0, 0), 3);
    ir[0][1] = 1'b0;
    iv[0][1] = 1'b1;
    id[0][15:8] = 8'hB1;
    id[0][7:0] = 8'hC1;
    cyc();
    id[0][15:8] = 8'hB2;
    id[0][7:0] = 8'hC2;
    cyc();
    chk("pre_flush_occ", 0, 1, occ_of(0, 1), 2);
    fl[0][1] = 1'b1;
    id[0][7:0] = 8'hC3;
    cyc();
    fl[0][1] = 1'b0;
    iv[0][1] = 1'b0;
    chk("flush_occ", 0, 1, occ_of(0, 1), 0);
    chk("flush_valid", 0, 1, 32'(ov[0][1]), 32'h0);
    id[0][7:0] = 8'hC4;
    cyc();
    iv[0][0] = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    iv[0][0] = 1'b1;
    id[0][7:0] = 8'hD1;
    cyc();
    id[0][7:0] = 8'hD2;
    cyc();
    iv[0][0] = 1'b0;
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    chk("srst_valid", 0, 0, 32'(ov[0][0]), 32'h0);
    chk("srst_occ", 0, 0, occ_of(0, 0), 0);
    chk("srst_data", 0, 0, 32'(od[0][7:0]), 32'h0A5);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_ghost", 0, 0, 32'(ov[0][0]), 32'h0);
    end
    for (int i = 0; i < 500; i++) begin
      srst = ($urandom_range(249) == 0);
      for (int k = 0; k < ND; k++) begin
        iv[k] = 4'($urandom());
        ir[k] = i < 150 ? 4'($urandom() & $urandom() & $urandom()) : 4'($urandom());
        id[k] = $urandom();
        for (int c = 0; c < 4; c++) fl[k][c] = ($urandom_range(24) == 0);
      end
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alwaysff_pipe_bank.md
ALWAYSFF_PIPE_BANK -- requirements
Module: alwaysff_pipe_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per channel (1..64).
REQ-002 SHALL have parameter DEPTH, default 3, meaning register stages per channel (1..16).
REQ-003 SHALL have parameter CHANNELS, default 2, meaning independent pipelines (1..8).
REQ-004 SHALL have parameter RESET_DATA, default 1, meaning 1 = data stages reset to INIT_VAL, 0 = only control state is reset.
REQ-005 SHALL have parameter INIT_VAL, default 0, meaning the WIDTH-bit data reset value.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 i_clk  input  1  sole clock, rising edge.
REQ-008 i_srst  input  1  synchronous active-high reset.
REQ-009 i_valid  input  CHANNELS  per-channel input valid.
REQ-010 o_ready  output  CHANNELS  per-channel input ready.
REQ-011 i_data  input  CHANNELS*WIDTH  channel c in bits [c*WIDTH +: WIDTH].
REQ-012 i_flush  input  CHANNELS  per-channel synchronous flush.
REQ-013 o_valid  output  CHANNELS  per-channel output valid.
REQ-014 i_ready  input  CHANNELS  per-channel downstream ready.
REQ-015 o_data  output  CHANNELS*WIDTH  same packing as i_data.
REQ-016 o_occ  output  CHANNELS*OW  per-channel stage occupancy, OW = $clog2(DEPTH+1).

Function
REQ-017 Each channel SHALL be an independent elastic pipeline of DEPTH registers, each with a valid bit v[k]; stage DEPTH-1 drives o_data/o_valid directly, with no combinational path from i_data to o_data.
REQ-018 Output handshake: move[DEPTH-1] = v[DEPTH-1] & i_ready; stage k<DEPTH-1 moves when v[k] & (!v[k+1] | move[k+1]).
REQ-019 o_ready[c] SHALL equal (!v[0] | move[0]) & !i_flush[c]; bubbles SHALL collapse, so a stalled output does not block filling empty stages.
REQ-020 Accept (i_valid & o_ready) at edge n into an empty channel SHALL give o_valid high after edge n+DEPTH-1, i.e. latency DEPTH cycles.
REQ-021 With i_ready held high and i_valid held high, throughput SHALL be one word per cycle per channel, order preserved, no loss or duplication.
REQ-022 o_valid SHALL stay high and o_data stable while i_ready is low.
REQ-023 o_occ SHALL count set valid bits: +1 on accept, -1 on output handshake, unchanged when both or neither occur; range 0..DEPTH, never wraps.
REQ-024 A full channel (o_occ = DEPTH) SHALL still accept in a cycle where an output handshake occurs.
REQ-025 i_flush[c] at an edge SHALL clear every v[k] of channel c and set o_occ[c] to 0; flush wins over a simultaneous accept (o_ready low) and a simultaneous output handshake (the word counts as delivered); data registers SHALL remain unchanged.
REQ-026 Channels SHALL NOT interact: flush, stall or reset state of one does not alter another.
REQ-027 Data registers SHALL load only on a stage move; gating on v avoids needless toggling.

Reset
REQ-028 i_srst high at an edge SHALL clear all v bits, set o_valid = 0 and o_occ = 0, and set o_ready = 1 from the following cycle.
REQ-029 With RESET_DATA=1, every data stage SHALL load INIT_VAL under reset, so o_data = INIT_VAL after reset.
REQ-030 With RESET_DATA=0, data stages SHALL NOT be reset, and o_data SHALL be don't-care while o_valid = 0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight words, with no partial output afterwards; i_srst takes priority over i_flush and handshakes.

Verification
REQ-032 DEPTH=3, i_ready=1, send 0x11,0x22,0x33 back-to-back on ch0 -> o_valid rises 3 cycles after the first accept, outputs 0x11,0x22,0x33 on consecutive cycles, o_occ peaks at 3.
REQ-033 Fill ch0 with i_ready=0 -> o_occ=3, o_ready=0. Then i_ready=1 with i_valid=1 -> accept and drain in the same cycle, o_occ stays 3.
REQ-034 Flush ch1 while o_occ=2 with i_valid=1 -> no accept, o_occ=0 and o_valid=0 next cycle, ch0 traffic unaffected.
REQ-035 Assert i_srst with 2 words in flight, RESET_DATA=1, INIT_VAL=0xA5 -> o_valid=0, o_occ=0, o_data=0xA5, and neither word ever appears.
REQ-036 Random i_valid/i_ready/i_flush for CHANNELS=4, DEPTH=1 and DEPTH=16 against a per-channel queue scoreboard -> exact order match and o_occ equal to the model each cycle.
